// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam logic [31:0] INSTR_BYTES = 32'd4;
    localparam int          IMEM_AW     = 6;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, instr}; head visible the cycle after push, no fall-through.
// Push is accepted while full when a pop happens in the same cycle; flush empties at the edge.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  fetch_entry_t entry_i,
    output fetch_entry_t head_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t   mem_q [DEPTH];
    fetch_entry_t   last_q;
    logic [AW:0]    wr_ptr_q;
    logic [AW:0]    rd_ptr_q;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // When empty the outputs keep showing the most recently retired head.
    assign head_o = empty_o ? last_q : mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            last_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (flush_i || pop_i) begin
                last_q <= head_o;
            end
            if (flush_i) begin
                rd_ptr_q <= wr_ptr_q;
            end else begin
                if (push_i) begin
                    mem_q[wr_ptr_q[AW-1:0]] <= entry_i;
                    wr_ptr_q                <= wr_ptr_q + 1'b1;
                end
                if (pop_i) begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, imem addressing, prefetch FIFO to decode; PC-to-valid latency 1 cycle.
// Stalls fetch when the FIFO is full with no pop; redirect flushes and wins. FETCH_PERF_CNT_EN adds counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                fetch_en,
    output logic [IMEM_AW-1:0]  imem_a,
    input  logic [31:0]         imem_rd,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         out_instr,
    output logic [31:0]         out_pc,
    output logic [31:0]         out_pc_plus4,
    input  logic                redirect_valid,
    input  logic [31:0]         redirect_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]         stall_cnt,
    output logic [31:0]         flush_cnt
`endif
);

    logic [31:0]  pc_q;
    logic [31:0]  pc_d;
    logic         push;
    logic         pop;
    logic         full;
    logic         empty;
    fetch_entry_t wr_entry;
    fetch_entry_t head;
    logic         unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign out_valid = !empty;
    assign pop       = out_valid && out_ready && !redirect_valid;
    assign push      = fetch_en && !redirect_valid && (!full || pop);

    // Only pc[7:2] addresses the 64-word memory, so fetch wraps every 256 bytes.
    assign imem_a = pc_q[IMEM_AW+1:2];

    assign wr_entry.pc    = pc_q;
    assign wr_entry.instr = imem_rd;

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = {redirect_pc[31:2], 2'b00};
        end else if (push) begin
            pc_d = pc_q + INSTR_BYTES;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .entry_i (wr_entry),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

    assign out_instr    = head.instr;
    assign out_pc       = head.pc;
    assign out_pc_plus4 = head.pc + INSTR_BYTES;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;
    logic        full_stall;

    // A redirect cycle is counted as a flush, never as a stall.
    assign full_stall = fetch_en && !redirect_valid && full && !pop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (full_stall) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (redirect_valid) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; inputs change and outputs are sampled on the falling edge.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        fetch_en = 1'b0;
    logic [5:0]  imem_a;
    logic [31:0] imem_rd;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] ram_word(input int idx);
        return 32'hC0DE_0000 + 32'(idx) * 32'h0000_0101;
    endfunction

    assign imem_rd = ram_word(int'(imem_a));

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .fetch_en       (fetch_en),
        .imem_a         (imem_a),
        .imem_rd        (imem_rd),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_pc_plus4   (out_pc_plus4),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
`endif
    );

    task automatic do_reset(input logic fe, input logic rdy);
        @(negedge clk);
        reset_n = 1'b0; fetch_en = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1; fetch_en = fe; out_ready = rdy;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", out_valid); end
        total++; if (out_instr !== 32'h0) begin bad++; $display("FAIL reset_instr got %h want 0", out_instr); end
        total++; if (out_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got %h want 0", out_pc); end
        total++; if (out_pc_plus4 !== 32'h4) begin bad++; $display("FAIL reset_pc4 got %h want 4", out_pc_plus4); end
        total++; if (imem_a !== 6'd0) begin bad++; $display("FAIL reset_imem_a got %0d want 0", imem_a); end
    endtask

    task automatic test_stream();
        do_reset(1'b1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d] got %b want 1", k, out_valid); end
            total++; if (out_pc !== 32'(4 * k)) begin bad++; $display("FAIL stream_pc[%0d] got %h want %h", k, out_pc, 32'(4 * k)); end
            total++; if (out_instr !== ram_word(k)) begin bad++; $display("FAIL stream_instr[%0d] got %h want %h", k, out_instr, ram_word(k)); end
            total++; if (out_pc_plus4 !== 32'(4 * k + 4)) begin bad++; $display("FAIL stream_pc4[%0d] got %h want %h", k, out_pc_plus4, 32'(4 * k + 4)); end
        end
    endtask

    task automatic test_backpressure();
        do_reset(1'b1, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            total++; if (imem_a !== ((i == 1) ? 6'd1 : 6'd2)) begin bad++; $display("FAIL bp_imem_a[%0d] got %0d want %0d", i, imem_a, (i == 1) ? 1 : 2); end
            total++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin bad++; $display("FAIL bp_head[%0d] got v=%b pc=%h want v=1 pc=0", i, out_valid, out_pc); end
        end
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            total++; if (out_valid !== 1'b1 || out_pc !== 32'(4 * k)) begin bad++; $display("FAIL bp_drain[%0d] got v=%b pc=%h want v=1 pc=%h", k, out_valid, out_pc, 32'(4 * k)); end
            total++; if (out_instr !== ram_word(k)) begin bad++; $display("FAIL bp_drain_instr[%0d] got %h want %h", k, out_instr, ram_word(k)); end
        end
    endtask

    task automatic test_redirect();
        do_reset(1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL redir_bubble got %b want 0", out_valid); end
        total++; if (imem_a !== 6'd16) begin bad++; $display("FAIL redir_imem_a got %0d want 16", imem_a); end
        redirect_valid = 1'b0;
        @(negedge clk);
        total++; if (out_valid !== 1'b1 || out_pc !== 32'h40) begin bad++; $display("FAIL redir_target got v=%b pc=%h want v=1 pc=40", out_valid, out_pc); end
        total++; if (out_instr !== ram_word(16)) begin bad++; $display("FAIL redir_instr got %h want %h", out_instr, ram_word(16)); end
        @(negedge clk);
        total++; if (out_pc !== 32'h44) begin bad++; $display("FAIL redir_next got %h want 44", out_pc); end
    endtask

    task automatic test_redirect_align();
        do_reset(1'b0, 1'b1);
        redirect_valid = 1'b1; redirect_pc = 32'h47;
        @(negedge clk);
        total++; if (imem_a !== 6'd17) begin bad++; $display("FAIL align_imem_a got %0d want 17", imem_a); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL align_valid got %b want 0", out_valid); end
        redirect_valid = 1'b0; fetch_en = 1'b1;
        @(negedge clk);
        total++; if (out_pc !== 32'h44 || out_instr !== ram_word(17)) begin bad++; $display("FAIL align_head got pc=%h instr=%h want pc=44 instr=%h", out_pc, out_instr, ram_word(17)); end
    endtask

    task automatic test_wrap();
        do_reset(1'b1, 1'b1);
        redirect_valid = 1'b1; redirect_pc = 32'hF8;
        @(negedge clk);
        redirect_valid = 1'b0;
        @(negedge clk);
        total++; if (out_pc !== 32'hF8) begin bad++; $display("FAIL wrap_f8 got %h want f8", out_pc); end
        @(negedge clk);
        total++; if (out_pc !== 32'hFC || imem_a !== 6'd0) begin bad++; $display("FAIL wrap_fc got pc=%h a=%0d want pc=fc a=0", out_pc, imem_a); end
        @(negedge clk);
        total++; if (out_pc !== 32'h100 || out_instr !== ram_word(0)) begin bad++; $display("FAIL wrap_100 got pc=%h instr=%h want pc=100 instr=%h", out_pc, out_instr, ram_word(0)); end
        total++; if (out_pc_plus4 !== 32'h104) begin bad++; $display("FAIL wrap_pc4 got %h want 104", out_pc_plus4); end
    endtask

    task automatic test_async_reset();
        do_reset(1'b1, 1'b1);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || out_pc !== 32'h0) begin bad++; $display("FAIL async_rst got v=%b pc=%h want v=0 pc=0", out_valid, out_pc); end
        #2 reset_n = 1'b1;
        @(negedge clk);
        total++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin bad++; $display("FAIL async_restart got v=%b pc=%h want v=1 pc=0", out_valid, out_pc); end
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_perf();
        do_reset(1'b1, 1'b0);
        repeat (2) @(negedge clk);
        total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL perf_stall0 got %0d want 0", stall_cnt); end
        repeat (3) @(negedge clk);
        total++; if (stall_cnt !== 32'd3) begin bad++; $display("FAIL perf_stall3 got %0d want 3", stall_cnt); end
        redirect_valid = 1'b1; redirect_pc = 32'h80;
        @(negedge clk);
        redirect_valid = 1'b0;
        total++; if (flush_cnt !== 32'd1 || stall_cnt !== 32'd3) begin bad++; $display("FAIL perf_flush got f=%0d s=%0d want f=1 s=3", flush_cnt, stall_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_redirect_align();
        test_wrap();
        test_async_reset();
`ifdef FETCH_PERF_CNT_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
